// File: rtl/vx_rop_logic_unit_pkg.sv
// Shared ROP logic-op types: op-code width and the 16 raster logic-op encodings.
package vx_rop_logic_unit_pkg;

  localparam int ROP_LOGIC_OP_BITS = 4;

  typedef enum logic [ROP_LOGIC_OP_BITS-1:0] {
    ROP_LOGIC_OP_CLEAR         = 4'd0,
    ROP_LOGIC_OP_AND           = 4'd1,
    ROP_LOGIC_OP_AND_REVERSE   = 4'd2,
    ROP_LOGIC_OP_COPY          = 4'd3,
    ROP_LOGIC_OP_AND_INVERTED  = 4'd4,
    ROP_LOGIC_OP_NOOP          = 4'd5,
    ROP_LOGIC_OP_XOR           = 4'd6,
    ROP_LOGIC_OP_OR            = 4'd7,
    ROP_LOGIC_OP_NOR           = 4'd8,
    ROP_LOGIC_OP_EQUIV         = 4'd9,
    ROP_LOGIC_OP_INVERT        = 4'd10,
    ROP_LOGIC_OP_OR_REVERSE    = 4'd11,
    ROP_LOGIC_OP_COPY_INVERTED = 4'd12,
    ROP_LOGIC_OP_OR_INVERTED   = 4'd13,
    ROP_LOGIC_OP_NAND          = 4'd14,
    ROP_LOGIC_OP_SET           = 4'd15
  } rop_logic_op_e;

endpackage

// File: rtl/vx_rop_logic_unit_if.sv
// Request/response bundle of the ROP logic-op stage; master drives requests, slave is the unit.
interface vx_rop_logic_unit_if
  import vx_rop_logic_unit_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 32,
  parameter int TAGW      = 8
);

  logic                         valid_in;
  logic                         ready_in;
  logic [ROP_LOGIC_OP_BITS-1:0] op;
  logic [NUM_LANES-1:0]         lane_mask;
  logic [DATAW/8-1:0]           write_mask;
  logic [NUM_LANES*DATAW-1:0]   src_color;
  logic [NUM_LANES*DATAW-1:0]   dst_color;
  logic [TAGW-1:0]              tag_in;

  logic                         valid_out;
  logic                         ready_out;
  logic [NUM_LANES*DATAW-1:0]   color_out;
  logic [NUM_LANES-1:0]         lane_mask_out;
  logic [TAGW-1:0]              tag_out;
  logic [31:0]                  perf_ops;
  logic [31:0]                  perf_stalls;

  modport master (
    output valid_in, op, lane_mask, write_mask, src_color, dst_color, tag_in, ready_out,
    input  ready_in, valid_out, color_out, lane_mask_out, tag_out, perf_ops, perf_stalls
  );

  modport slave (
    input  valid_in, op, lane_mask, write_mask, src_color, dst_color, tag_in, ready_out,
    output ready_in, valid_out, color_out, lane_mask_out, tag_out, perf_ops, perf_stalls
  );

endinterface

// File: rtl/vx_rop_logic_lane.sv
// One colour lane: bitwise raster logic op, per-byte write-mask merge with dst, lane-mask bypass.
module vx_rop_logic_lane
  import vx_rop_logic_unit_pkg::*;
#(
  parameter int DATAW = 32
) (
  input  logic [ROP_LOGIC_OP_BITS-1:0] i_op,
  input  logic                         i_lane_en,
  input  logic [DATAW/8-1:0]           i_write_mask,
  input  logic [DATAW-1:0]             i_src,
  input  logic [DATAW-1:0]             i_dst,
  output logic [DATAW-1:0]             o_color
);

  logic [DATAW-1:0] w_rop;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_rop = '0;
    case (rop_logic_op_e'(i_op))
      ROP_LOGIC_OP_CLEAR:         w_rop = '0;
      ROP_LOGIC_OP_AND:           w_rop = i_src & i_dst;
      ROP_LOGIC_OP_AND_REVERSE:   w_rop = i_src & ~i_dst;
      ROP_LOGIC_OP_COPY:          w_rop = i_src;
      ROP_LOGIC_OP_AND_INVERTED:  w_rop = ~i_src & i_dst;
      ROP_LOGIC_OP_NOOP:          w_rop = i_dst;
      ROP_LOGIC_OP_XOR:           w_rop = i_src ^ i_dst;
      ROP_LOGIC_OP_OR:            w_rop = i_src | i_dst;
      ROP_LOGIC_OP_NOR:           w_rop = ~(i_src | i_dst);
      ROP_LOGIC_OP_EQUIV:         w_rop = ~(i_src ^ i_dst);
      ROP_LOGIC_OP_INVERT:        w_rop = ~i_dst;
      ROP_LOGIC_OP_OR_REVERSE:    w_rop = i_src | ~i_dst;
      ROP_LOGIC_OP_COPY_INVERTED: w_rop = ~i_src;
      ROP_LOGIC_OP_OR_INVERTED:   w_rop = ~i_src | i_dst;
      ROP_LOGIC_OP_NAND:          w_rop = ~(i_src & i_dst);
      ROP_LOGIC_OP_SET:           w_rop = '1;
    endcase
  end

  // An inactive lane keeps dst whole, even for CLEAR/SET.
  always_comb begin
    o_color = i_dst;
    if (i_lane_en) begin
      for (int b = 0; b < DATAW/8; b++) begin
        if (i_write_mask[b]) o_color[b*8 +: 8] = w_rop[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/vx_rop_logic_unit.sv
// Multi-lane ROP logic-op stage: combinational op/merge feeding a LATENCY-deep elastic
// pipeline with collapsing bubbles, plus output handshake and stall counters.
module vx_rop_logic_unit
  import vx_rop_logic_unit_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 32,
  parameter int LATENCY   = 2,
  parameter int TAGW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_rop_logic_unit_if.slave   bus
);

  localparam int LW = NUM_LANES * DATAW;

  logic [LW-1:0] w_merged;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    vx_rop_logic_lane #(
      .DATAW (DATAW)
    ) u_lane (
      .i_op         (bus.op),
      .i_lane_en    (bus.lane_mask[g]),
      .i_write_mask (bus.write_mask),
      .i_src        (bus.src_color[g*DATAW +: DATAW]),
      .i_dst        (bus.dst_color[g*DATAW +: DATAW]),
      .o_color      (w_merged[g*DATAW +: DATAW])
    );
  end

  logic [LATENCY-1:0]                r_valid;
  logic [LATENCY-1:0][LW-1:0]        r_color;
  logic [LATENCY-1:0][NUM_LANES-1:0] r_mask;
  logic [LATENCY-1:0][TAGW-1:0]      r_tag;
  logic [LATENCY-1:0]                w_load;
  logic [31:0]                       r_perf_ops;
  logic [31:0]                       r_perf_stalls;
  logic                              w_fire;
  logic                              w_stall;

  // Stage k advances if downstream accepts or any stage at or after k is a bubble;
  // this closed form keeps ready_in free of any valid_in dependency.
  always_comb begin
    w_load = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_load[k] = bus.ready_out | ((~r_valid >> k) != '0);
    end
  end

  // NOTE: pipeline data is reset along with the valids so outputs read 0 right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_color <= '0;
      r_mask  <= '0;
      r_tag   <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage samples its neighbour's old value.
      if (w_load[0]) begin
        r_valid[0] <= bus.valid_in;
        if (bus.valid_in) begin
          r_color[0] <= w_merged;
          r_mask[0]  <= bus.lane_mask;
          r_tag[0]   <= bus.tag_in;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_color[k] <= r_color[k-1];
            r_mask[k]  <= r_mask[k-1];
            r_tag[k]   <= r_tag[k-1];
          end
        end
      end
    end
  end

  assign w_fire  = r_valid[LATENCY-1] & bus.ready_out;
  assign w_stall = r_valid[LATENCY-1] & ~bus.ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_ops    <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_fire)  r_perf_ops    <= r_perf_ops + 32'd1;
      if (w_stall) r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign bus.ready_in      = w_load[0];
  assign bus.valid_out     = r_valid[LATENCY-1];
  assign bus.color_out     = r_color[LATENCY-1];
  assign bus.lane_mask_out = r_mask[LATENCY-1];
  assign bus.tag_out       = r_tag[LATENCY-1];
  assign bus.perf_ops      = r_perf_ops;
  assign bus.perf_stalls   = r_perf_stalls;

endmodule

// File: tb/tb_vx_rop_logic_unit.sv
// Bench for vx_rop_logic_unit: directed steps plus a randomized op sweep checked against a
// truth-table reference model and an in-order scoreboard.
module tb_vx_rop_logic_unit;
  import vx_rop_logic_unit_pkg::*;

  localparam int NUM_LANES = 4;
  localparam int DATAW     = 32;
  localparam int LATENCY   = 2;
  localparam int TAGW      = 8;
  localparam int LW        = NUM_LANES * DATAW;
  localparam int WMW       = DATAW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_rop_logic_unit_if #(.NUM_LANES(NUM_LANES), .DATAW(DATAW), .TAGW(TAGW)) bus ();

  vx_rop_logic_unit #(
    .NUM_LANES (NUM_LANES),
    .DATAW     (DATAW),
    .LATENCY   (LATENCY),
    .TAGW      (TAGW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [LW-1:0]        color;
    logic [NUM_LANES-1:0] lmask;
    logic [TAGW-1:0]      tag;
    int                   acc;
  } exp_t;

  exp_t            exp_q[$];
  logic [TAGW-1:0] out_tags[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int last_ro_low = -1;
  int exp_ops = 0;
  int exp_stalls = 0;
  bit rnd_done;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each op code is the truth table of f(s,d), indexed by {~s,~d}.
  function automatic logic [DATAW-1:0] ref_lane(input logic [3:0] op, input logic [DATAW-1:0] s,
                                                input logic [DATAW-1:0] d, input logic en,
                                                input logic [WMW-1:0] wm);
    logic [DATAW-1:0] r;
    logic [1:0]       idx;
    if (!en) return d;
    for (int j = 0; j < DATAW; j++) begin
      idx  = {~s[j], ~d[j]};
      r[j] = op[idx];
    end
    for (int b = 0; b < WMW; b++) if (!wm[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [LW-1:0] ref_color(input logic [3:0] op, input logic [NUM_LANES-1:0] lm,
                                              input logic [WMW-1:0] wm, input logic [LW-1:0] s,
                                              input logic [LW-1:0] d);
    logic [LW-1:0] r;
    for (int l = 0; l < NUM_LANES; l++)
      r[l*DATAW +: DATAW] = ref_lane(op, s[l*DATAW +: DATAW], d[l*DATAW +: DATAW], lm[l], wm);
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd_color();
    logic [LW-1:0] v;
    for (int l = 0; l < NUM_LANES; l++) v[l*DATAW +: DATAW] = $urandom();
    return v;
  endfunction

  // Scoreboard monitor, sampling at the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_ops     = 0;
      exp_stalls  = 0;
      last_ro_low = cycle;
    end else begin
      exp_t e;
      cycle++;
      if (!bus.ready_out) last_ro_low = cycle;
      if (bus.valid_in && bus.ready_in) begin
        e.color = ref_color(bus.op, bus.lane_mask, bus.write_mask, bus.src_color, bus.dst_color);
        e.lmask = bus.lane_mask;
        e.tag   = bus.tag_in;
        e.acc   = cycle;
        exp_q.push_back(e);
      end
      if (bus.valid_out && !bus.ready_out) exp_stalls++;
      if (bus.valid_out && bus.ready_out) begin
        exp_ops++;
        check_n("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_color", bus.color_out, e.color);
          check_n("out_lane_mask", 32'(bus.lane_mask_out), 32'(e.lmask));
          check_n("out_tag", 32'(bus.tag_out), 32'(e.tag));
          if (last_ro_low < e.acc) check_n("out_latency", cycle - e.acc, LATENCY);
          out_tags.push_back(bus.tag_out);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [NUM_LANES-1:0] lm, input logic [WMW-1:0] wm,
                      input logic [LW-1:0] s, input logic [LW-1:0] d, input logic [TAGW-1:0] tag);
    int waited = 0;
    bus.valid_in = 1'b1;  bus.op = op;  bus.lane_mask = lm;  bus.write_mask = wm;
    bus.src_color = s;    bus.dst_color = d;  bus.tag_in = tag;
    while (1) begin
      @(negedge clk);
      if (bus.ready_in) break;
      waited++;
      if (waited > 200) begin
        check_n("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  // Send with ready_out high and observe the result exactly LATENCY cycles after accept.
  task automatic send_lat(input logic [3:0] op, input logic [NUM_LANES-1:0] lm, input logic [WMW-1:0] wm,
                          input logic [LW-1:0] s, input logic [LW-1:0] d, input logic [TAGW-1:0] tag,
                          input string name, output logic [LW-1:0] obs);
    send(op, lm, wm, s, d, tag);
    @(negedge clk);
    check_n({name, "_not_early"}, 32'(bus.valid_out), 32'd0);
    @(negedge clk);
    check_n({name, "_valid_at_lat"}, 32'(bus.valid_out), 32'd1);
    obs = bus.color_out;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check_n("drain_done", 32'(exp_q.size() == 0 && !bus.valid_out), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0]   s, d, obs, snap_c;
    logic [TAGW-1:0] snap_t;
    logic [3:0]      snap_m;
    int              w;

    bus.valid_in = 1'b0;  bus.op = '0;  bus.lane_mask = '0;  bus.write_mask = '0;
    bus.src_color = '0;   bus.dst_color = '0;  bus.tag_in = '0;  bus.ready_out = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_n("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_n("rst_ready_in", 32'(bus.ready_in), 32'd1);
    check("rst_color_out", bus.color_out, '0);
    check_n("rst_lane_mask_out", 32'(bus.lane_mask_out), 32'd0);
    check_n("rst_tag_out", 32'(bus.tag_out), 32'd0);
    check_n("rst_perf_ops", bus.perf_ops, 32'd0);
    check_n("rst_perf_stalls", bus.perf_stalls, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // XOR on lane 0, result exactly LATENCY cycles after accept.
    s = rnd_color();  d = rnd_color();
    s[31:0] = 32'hFF00FF00;  d[31:0] = 32'h0F0F0F0F;
    send_lat(ROP_LOGIC_OP_XOR, 4'hF, 4'hF, s, d, 8'h10, "xor", obs);
    check_n("xor_lane0", obs[31:0], 32'hF00FF00F);
    drain();
    check_n("xor_perf_ops", bus.perf_ops, 32'd1);

    // AND with partial byte write mask.
    s = rnd_color();  d = rnd_color();
    s[31:0] = 32'h0F0F0F0F;  d[31:0] = 32'hFFFFFFFF;
    send_lat(ROP_LOGIC_OP_AND, 4'hF, 4'b0101, s, d, 8'h11, "and_wm", obs);
    check_n("and_wm_lane0", obs[31:0], 32'hFF0FFF0F);

    // NAND, full mask.
    s = rnd_color();  d = rnd_color();
    s[31:0] = 32'hFFFFFFFF;  d[31:0] = 32'h0000FFFF;
    send_lat(ROP_LOGIC_OP_NAND, 4'hF, 4'hF, s, d, 8'h12, "nand", obs);
    check_n("nand_lane0", obs[31:0], 32'hFFFF0000);

    // SET with a single active lane: inactive lanes keep dst.
    s = rnd_color();
    d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    send_lat(ROP_LOGIC_OP_SET, 4'b0010, 4'hF, s, d, 8'h13, "set_lm", obs);
    check("set_lm_lanes", obs, {32'h44444444, 32'h33333333, 32'hFFFFFFFF, 32'h11111111});
    drain();
    check_n("dir_perf_ops", bus.perf_ops, 32'd4);
    check_n("dir_perf_stalls", bus.perf_stalls, 32'd0);

    // Backpressure: six tagged transactions, ready_out low in relative cycles 3..7.
    out_tags.delete();
    fork
      begin
        for (int i = 1; i <= 6; i++)
          send(ROP_LOGIC_OP_COPY, 4'hF, 4'hF, rnd_color(), rnd_color(), 8'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.ready_out = 1'b0;
        @(negedge clk);
        check_n("bp_valid_in_stall", 32'(bus.valid_out), 32'd1);
        check_n("bp_head_tag", 32'(bus.tag_out), 32'd2);
        snap_c = bus.color_out;  snap_t = bus.tag_out;  snap_m = bus.lane_mask_out;
        repeat (2) @(negedge clk);
        check_n("bp_ready_in_low", 32'(bus.ready_in), 32'd0);
        repeat (2) @(negedge clk);
        check("bp_color_stable", bus.color_out, snap_c);
        check_n("bp_tag_stable", 32'(bus.tag_out), 32'(snap_t));
        check_n("bp_mask_stable", 32'(bus.lane_mask_out), 32'(snap_m));
        @(posedge clk); #1;
        bus.ready_out = 1'b1;
      end
    join
    drain();
    check_n("bp_out_count", out_tags.size(), 32'd6);
    for (int i = 0; i < out_tags.size(); i++)
      check_n($sformatf("bp_tag_order%0d", i), 32'(out_tags[i]), 32'(i + 1));
    check_n("bp_perf_stalls", bus.perf_stalls, 32'd5);
    check_n("bp_perf_ops", bus.perf_ops, 32'd10);

    // Random sweep over all ops with random masks and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 192; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.op = 4'($urandom());  bus.tag_in = 8'($urandom());
            bus.src_color = rnd_color();  bus.dst_color = rnd_color();
            @(posedge clk); #1;
          end
          send(4'(i % 16), 4'($urandom()), 4'($urandom()), rnd_color(), rnd_color(), 8'(i));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.ready_out = ($urandom_range(0, 3) != 0);
        end
        bus.ready_out = 1'b1;
      end
    join
    drain();
    check_n("rnd_perf_ops_model", bus.perf_ops, 32'(exp_ops));
    check_n("rnd_perf_ops_total", bus.perf_ops, 32'd202);
    check_n("rnd_perf_stalls_model", bus.perf_stalls, 32'(exp_stalls));

    // Asynchronous reset with two transactions in flight and the output stalled.
    bus.ready_out = 1'b0;
    send(ROP_LOGIC_OP_OR, 4'hF, 4'hF, rnd_color(), rnd_color(), 8'hA0);
    send(ROP_LOGIC_OP_OR, 4'hF, 4'hF, rnd_color(), rnd_color(), 8'hA1);
    w = 0;
    while (!bus.valid_out && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_n("pre_rst_valid_out", 32'(bus.valid_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_n("mid_rst_valid_out", 32'(bus.valid_out), 32'd0);
    check_n("mid_rst_ready_in", 32'(bus.ready_in), 32'd1);
    check("mid_rst_color_out", bus.color_out, '0);
    check_n("mid_rst_tag_out", 32'(bus.tag_out), 32'd0);
    check_n("mid_rst_lane_mask_out", 32'(bus.lane_mask_out), 32'd0);
    check_n("mid_rst_perf_ops", bus.perf_ops, 32'd0);
    check_n("mid_rst_perf_stalls", bus.perf_stalls, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.ready_out = 1'b1;
    @(posedge clk); #1;
    check_n("post_rst_idle", 32'(bus.valid_out), 32'd0);

    s = rnd_color();  d = rnd_color();
    send_lat(ROP_LOGIC_OP_COPY_INVERTED, 4'b1011, 4'b1100, s, d, 8'h55, "post_rst", obs);
    check("post_rst_color", obs, ref_color(ROP_LOGIC_OP_COPY_INVERTED, 4'b1011, 4'b1100, s, d));
    check_n("post_rst_tag", 32'(bus.tag_out), 32'h55);
    drain();
    check_n("post_rst_perf_ops", bus.perf_ops, 32'd1);
    check_n("post_rst_perf_stalls", bus.perf_stalls, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_rop_logic_unit.md
Name: vx_rop_logic_unit

Overview:
Multi-lane, pipelined ROP logic-op stage with a valid/ready handshake. It applies one of 16 raster logic operations to NUM_LANES source/destination colour pairs per transaction. It then merges the result with the destination under a per-lane active mask and a per-byte colour write mask. It sits between the blend stage and the framebuffer write port of the ROP unit, and carries an opaque tag for request tracking.

Parameters:
NUM_LANES, 4, number of colour lanes processed per transaction (>=1)
DATAW, 32, colour width per lane in bits (multiple of 8)
LATENCY, 2, pipeline stages from input handshake to valid_out (>=1)
TAGW, 8, width of the pass-through tag

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  input transaction valid
ready_in  out  1  unit can accept an input this cycle
op  in  ROP_LOGIC_OP_BITS(4)  logic op code, sampled with valid_in
lane_mask  in  NUM_LANES  1 = lane active; an inactive lane outputs dst unchanged
write_mask  in  DATAW/8  per-byte colour write enable, common to all lanes
src_color  in  NUM_LANES*DATAW  source colours, lane i at [i*DATAW +: DATAW]
dst_color  in  NUM_LANES*DATAW  destination colours, same packing
tag_in  in  TAGW  opaque tag
valid_out  out  1  output transaction valid
ready_out  in  1  downstream accepts the output
color_out  out  NUM_LANES*DATAW  merged result colours
lane_mask_out  out  NUM_LANES  lane_mask delayed with its transaction
tag_out  out  TAGW  tag delayed with its transaction
perf_ops  out  32  count of completed output handshakes
perf_stalls  out  32  cycles with valid_out=1 and ready_out=0

Behaviour:
- Op encoding, 0..15: CLEAR, AND, AND_REVERSE(s&~d), COPY, AND_INVERTED(~s&d), NOOP, XOR, OR, NOR, EQUIV, INVERT(~d), OR_REVERSE(s|~d), COPY_INVERTED, OR_INVERTED(~s|d), NAND, SET. All ops are bitwise over DATAW.
- Per lane: r = f(op,s,d).
- Byte merge: out byte b = write_mask[b] ? r byte b : d byte b.
- If lane_mask[i]=0, lane i out = d. Applies to all ops, including CLEAR and SET.
- The logic function and merge are computed combinationally before stage 0 register.
- Pipeline is LATENCY register stages, each holding {valid, color, lane_mask, tag}.
- Stage k loads when it is empty or stage k+1 loads that cycle. For the last stage, "stage k+1 loads" means ready_out=1. Bubbles collapse.
- ready_in = stage 0 loads condition. It is combinational from ready_out through the stage valids. There is no combinational path from valid_in to ready_in.
- Input handshake: valid_in & ready_in. Output handshake: valid_out & ready_out.
- Latency: with ready_out held at 1, data accepted in cycle t appears with valid_out=1 in cycle t+LATENCY. Throughput is 1 per cycle.
- Stall: while valid_out=1 and ready_out=0, color_out, lane_mask_out and tag_out stay stable. Upstream stages fill, then ready_in drops. Inputs not handshaked are ignored.
- Transactions leave in order, never duplicated or dropped.
- perf_ops increments on each output handshake. perf_stalls increments on each stall cycle. Both wrap from 0xFFFFFFFF to 0.
- Reset (asynchronous, any time, including mid-stall): all stage valids = 0 and stage data = 0. Outputs become valid_out=0, ready_in=1, color_out=0, lane_mask_out=0, tag_out=0, perf_ops=0, perf_stalls=0. In-flight transactions are discarded.
- Out-of-range op cannot occur (4-bit full decode).

Decomposition:
- Shared package (rop types): op encoding constants and the op-bits width constant. Existing ROP_LOGIC_OP_* definitions are reused, not duplicated.
- Sub-module vx_rop_logic_lane: combinational single-lane op + byte merge + lane-mask bypass, parameterised by DATAW. It is instantiated NUM_LANES times via generate.
- Pipeline registers and perf counters stay in the top module.

Test Plan:
- XOR, lane 0: s=0xFF00FF00, d=0x0F0F0F0F, write_mask=4'hF, lane_mask=4'hF, ready_out=1 -> lane 0 color_out=0xF00FF00F exactly 2 cycles after accept; perf_ops=1.
- AND with write_mask=4'b0101: s=0x0F0F0F0F, d=0xFFFFFFFF -> 0xFF0FFF0F. NAND: s=0xFFFFFFFF, d=0x0000FFFF, full mask -> 0xFFFF0000.
- lane_mask=4'b0010, op SET, d lanes = 0x11111111,0x22222222,0x33333333,0x44444444 -> out lanes = 0x11111111,0xFFFFFFFF,0x33333333,0x44444444.
- Backpressure: stream 6 transactions tagged 1..6 with ready_out=0 for cycles 3..7 -> ready_in falls once both stages are full. Outputs hold stable; tags 1..6 emerge in order, none lost. perf_stalls equals the stall cycles observed.
- All 16 ops swept with random s/d, both lanes masks, ready_out randomly toggled -> scoreboard match. Latency is exactly LATENCY whenever there is no stall.
- Assert reset while 2 transactions are in flight and valid_out=1 -> valid_out=0, ready_in=1, counters 0 immediately. The first post-reset transaction emerges correctly with no stale data.
